// File: rtl/demux_stream_1to4.sv
`default_nettype none
// ============================================================================
// Module      : demux_stream_1to4
// Description : Registered 1-to-4 stream demultiplexer. It takes one word per
//               cycle on a single valid/ready input and steers it into one of
//               four one-entry output holding registers. The target channel
//               comes either from the per-word select tag or from an internal
//               round-robin pointer.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               rr_mode    - 1: route by rr_ptr, 0: route by in_sel
//               in_valid   - input word present
//               in_ready   - input word accepted this cycle (if valid)
//               in_sel     - target channel when rr_mode=0
//               in_data    - input word
//               out_valid  - bit k: channel k holds a word
//               out_ready  - bit k: channel k consumer takes the word
//               out_data   - channel k word at [k*WIDTH +: WIDTH]
//               rr_ptr     - current round-robin pointer
// Revision    : 1.0 - initial release
// ============================================================================
module demux_stream_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rr_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [1:0]         rr_ptr
);

    localparam int C_NUM_CH = 4;

    logic [1:0] r_rr_ptr_q;
    logic [1:0] w_rr_ptr_d;
    logic [1:0] w_target;
    logic       w_accept;

    // Only the target channel gates acceptance, so a stalled neighbour never
    // blocks traffic to other lanes. A full target may still accept when it
    // drains in the same cycle, which gives bubble-free refill.
    always_comb begin
        w_target = rr_mode ? r_rr_ptr_q : in_sel;
        in_ready = ~out_valid[w_target] | out_ready[w_target];
        w_accept = in_valid & in_ready;
    end

    // Pointer moves only when a word is actually routed by it.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_accept && rr_mode) begin
            w_rr_ptr_d = r_rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr_q <= 2'd0;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign rr_ptr = r_rr_ptr_q;

    for (genvar k = 0; k < C_NUM_CH; k++) begin : g_chan
        localparam logic [1:0] C_IDX = 2'(k);

        logic             w_load;
        logic             r_valid_q;
        logic             w_valid_d;
        logic [WIDTH-1:0] r_data_q;
        logic [WIDTH-1:0] w_data_d;

        // Load has priority over drain: a simultaneous drain and refill
        // leaves the slot full with the new word.
        always_comb begin
            w_load    = w_accept && (w_target == C_IDX);
            w_valid_d = r_valid_q;
            w_data_d  = r_data_q;
            if (w_load) begin
                w_valid_d = 1'b1;
                w_data_d  = in_data;
            end else if (r_valid_q && out_ready[k]) begin
                w_valid_d = 1'b0;
            end
        end

        // Data is left in place after a drain; it only changes on a load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
            end else begin
                r_valid_q <= w_valid_d;
                r_data_q  <= w_data_d;
            end
        end

        assign out_valid[k]                = r_valid_q;
        assign out_data[k*WIDTH +: WIDTH]  = r_data_q;
    end : g_chan

endmodule : demux_stream_1to4
`default_nettype wire
